// File: rtl/kms_event_sched.sv
// rtl/kms_event_sched.sv - mouse/keyboard event merger with key FIFO and single-slot output register.
// Define KMS_RR_EN for round-robin key/mouse arbitration; default build gives keys fixed priority.
module kms_event_sched #(
  parameter int KBD_DEPTH = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        kms_strobe,
  input  logic [1:0]  kms_type,
  input  logic [7:0]  kms_data,
  input  logic [2:0]  mouse_buttons,
  output logic        ev_valid,
  output logic [1:0]  ev_kind,
  output logic [15:0] ev_data,
  output logic [2:0]  ev_btn,
  input  logic        ev_ready,
  output logic        kbd_overflow,
  output logic [4:0]  kbd_level
);

  localparam int PW = $clog2(KBD_DEPTH);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t         state_q, state_d;
  logic [7:0]     acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic           pend_q, pend_d;
  logic [2:0]     last_btn_q, last_btn_d;
  logic           ovf_q, ovf_d;
  logic [4:0]     level_q, level_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]     kind_q, kind_d;
  logic [15:0]    data_q, data_d;
  logic [2:0]     btn_q, btn_d;
  logic [8:0]     mem [KBD_DEPTH];
  logic           can_load, grant_key, grant_mouse, push, push_ok;
`ifdef KMS_RR_EN
  logic           last_key_q, last_key_d;
`endif

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] s;
    s = $signed({a[7], a}) + $signed({b[7], b});
    if (s > 9'sd127)       return 8'h7F;
    else if (s < -9'sd128) return 8'h80;
    else                   return s[7:0];
  endfunction

  always_comb begin
    can_load = (state_q == S_IDLE) || ev_ready;
`ifdef KMS_RR_EN
    grant_key = can_load && (level_q != 5'd0) && (!pend_q || !last_key_q);
`else
    grant_key = can_load && (level_q != 5'd0);
`endif
    grant_mouse = can_load && pend_q && !grant_key;
    push        = kms_strobe && kms_type[1];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok     = push && ((level_q != 5'(KBD_DEPTH)) || grant_key);
  end

  always_comb begin
    state_d    = state_q;
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    pend_d     = pend_q;
    last_btn_d = last_btn_q;
    ovf_d      = ovf_q;
    level_d    = level_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    kind_d     = kind_q;
    data_d     = data_q;
    btn_d      = btn_q;
`ifdef KMS_RR_EN
    last_key_d = last_key_q;
`endif
    case (state_q)
      S_IDLE:  if (grant_key || grant_mouse) state_d = S_HOLD;
      S_HOLD:  if (ev_ready && !grant_key && !grant_mouse) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (grant_key) begin
      kind_d   = mem[rd_ptr_q][8] ? 2'd2 : 2'd1;
      data_d   = {8'h00, mem[rd_ptr_q][7:0]};
      btn_d    = 3'b000;
      rd_ptr_d = rd_ptr_q + PW'(1);
`ifdef KMS_RR_EN
      last_key_d = 1'b1;
`endif
    end else if (grant_mouse) begin
      kind_d     = 2'd0;
      data_d     = {acc_x_q, acc_y_q};
      btn_d      = mouse_buttons;
      acc_x_d    = 8'h00;
      acc_y_d    = 8'h00;
      pend_d     = 1'b0;
      last_btn_d = mouse_buttons;
`ifdef KMS_RR_EN
      last_key_d = 1'b0;
`endif
    end
    // Strobe accumulates after any grant clear, so a delta landing in the grant cycle survives.
    if (kms_strobe && !kms_type[1]) begin
      if (kms_type[0]) acc_y_d = sat_add(acc_y_d, kms_data);
      else             acc_x_d = sat_add(acc_x_d, kms_data);
      pend_d = 1'b1;
    end
    if (mouse_buttons != last_btn_d) pend_d = 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (push && !push_ok) ovf_d = 1'b1;
    case ({push_ok, grant_key})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      acc_x_q    <= 8'h00;
      acc_y_q    <= 8'h00;
      pend_q     <= 1'b0;
      last_btn_q <= 3'b000;
      ovf_q      <= 1'b0;
      level_q    <= 5'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      kind_q     <= 2'd0;
      data_q     <= 16'h0000;
      btn_q      <= 3'b000;
`ifdef KMS_RR_EN
      last_key_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      pend_q     <= pend_d;
      last_btn_q <= last_btn_d;
      ovf_q      <= ovf_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      kind_q     <= kind_d;
      data_q     <= data_d;
      btn_q      <= btn_d;
`ifdef KMS_RR_EN
      last_key_q <= last_key_d;
`endif
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_ptr_q] <= {kms_type[0], kms_data};
  end

  assign ev_valid     = (state_q == S_HOLD);
  assign ev_kind      = kind_q;
  assign ev_data      = data_q;
  assign ev_btn       = btn_q;
  assign kbd_overflow = ovf_q;
  assign kbd_level    = level_q;

endmodule

// File: tb/tb_kms_event_sched.sv
// tb/tb_kms_event_sched.sv - directed and random checks of kms_event_sched against a queue-based model.
module tb_kms_event_sched;

  localparam int DEPTH = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        kms_strobe;
  logic [1:0]  kms_type;
  logic [7:0]  kms_data;
  logic [2:0]  mouse_buttons;
  logic        ev_valid;
  logic [1:0]  ev_kind;
  logic [15:0] ev_data;
  logic [2:0]  ev_btn;
  logic        ev_ready;
  logic        kbd_overflow;
  logic [4:0]  kbd_level;

  kms_event_sched #(.KBD_DEPTH(DEPTH)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .kms_strobe(kms_strobe), .kms_type(kms_type),
    .kms_data(kms_data), .mouse_buttons(mouse_buttons), .ev_valid(ev_valid), .ev_kind(ev_kind),
    .ev_data(ev_data), .ev_btn(ev_btn), .ev_ready(ev_ready), .kbd_overflow(kbd_overflow),
    .kbd_level(kbd_level)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad = 0;

  // Reference model: accumulators as ints, key FIFO as a queue, output slot as plain fields.
  int         m_ax, m_ay;
  bit         m_pend, m_last_key, m_valid, m_ovf;
  bit [2:0]   m_lb, m_btn;
  bit [1:0]   m_kind;
  bit [15:0]  m_data;
  bit [8:0]   m_kq[$];
  logic [17:0] got[$];

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_reset();
    m_ax = 0; m_ay = 0; m_pend = 0; m_last_key = 0; m_valid = 0; m_ovf = 0;
    m_lb = 0; m_btn = 0; m_kind = 0; m_data = 0; m_kq.delete();
  endtask

  task automatic model_edge();
    bit can, hk, gk, gm;
    bit [8:0] e;
    can = !m_valid || ev_ready;
    hk = m_kq.size() > 0;
    gk = 0; gm = 0;
    if (can && hk && m_pend) begin
`ifdef KMS_RR_EN
      gk = !m_last_key;
`else
      gk = 1;
`endif
      gm = !gk;
    end else if (can) begin
      gk = hk;
      gm = m_pend;
    end
    if (gk) begin
      e = m_kq.pop_front();
      m_valid = 1; m_kind = e[8] ? 2'd2 : 2'd1; m_data = {8'h00, e[7:0]}; m_btn = 0;
      m_last_key = 1;
    end else if (gm) begin
      m_valid = 1; m_kind = 0; m_data = {8'(m_ax), 8'(m_ay)}; m_btn = mouse_buttons;
      m_ax = 0; m_ay = 0; m_pend = 0; m_lb = mouse_buttons; m_last_key = 0;
    end else if (m_valid && ev_ready) begin
      m_valid = 0;
    end
    if (kms_strobe && !kms_type[1]) begin
      if (kms_type[0]) m_ay = sat(m_ay + int'($signed(kms_data)));
      else             m_ax = sat(m_ax + int'($signed(kms_data)));
      m_pend = 1;
    end
    if (kms_strobe && kms_type[1]) begin
      if (m_kq.size() < DEPTH) m_kq.push_back({kms_type[0], kms_data});
      else m_ovf = 1;
    end
    if (mouse_buttons != m_lb) m_pend = 1;
  endtask

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ev_valid", 18'(ev_valid), 18'(m_valid));
    chk("ev_kind", 18'(ev_kind), 18'(m_kind));
    chk("ev_data", 18'(ev_data), 18'(m_data));
    chk("ev_btn", 18'(ev_btn), 18'(m_btn));
    chk("kbd_level", 18'(kbd_level), 18'(m_kq.size()));
    chk("kbd_overflow", 18'(kbd_overflow), 18'(m_ovf));
  endtask

  task automatic tick();
    if (ev_valid === 1'b1 && ev_ready === 1'b1) got.push_back({ev_kind, ev_data});
    @(posedge clk_sys);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic strobe(input logic [1:0] t, input logic [7:0] d);
    kms_strobe = 1'b1; kms_type = t; kms_data = d;
    tick();
    kms_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_got(input string tag, input int idx, input logic [17:0] exp);
    logic [17:0] v;
    v = (idx < got.size()) ? got[idx] : 18'h3FFFF;
    chk(tag, v, exp);
  endtask

  logic [17:0] exp37 [3];

  initial begin
    reset_n = 1'b0; kms_strobe = 1'b0; kms_type = 2'd0; kms_data = 8'h00;
    mouse_buttons = 3'b000; ev_ready = 1'b0;
    model_reset();
    #12;
    check_all();
    reset_n = 1'b1;
    idle(2);

    // Key sequence with consumer always ready; first valid two cycles after the strobe.
    ev_ready = 1'b1; got.delete();
    strobe(2'd2, 8'h45);
    chk("lat_n1", 18'(ev_valid), 18'h0);
    strobe(2'd2, 8'h46);
    chk("lat_n2", 18'(ev_valid), 18'h1);
    strobe(2'd3, 8'h10);
    idle(6);
    chk("got_cnt34", 18'(got.size()), 18'd3);
    chk_got("key0", 0, {2'd1, 16'h0045});
    chk_got("key1", 1, {2'd1, 16'h0046});
    chk_got("key2", 2, {2'd2, 16'h0010});

    // Mouse accumulation with saturation while the output slot is occupied.
    ev_ready = 1'b0; got.delete();
    strobe(2'd2, 8'h33);
    tick();
    strobe(2'd0, 8'd100);
    strobe(2'd0, 8'd100);
    strobe(2'd1, 8'hFD);
    idle(2);
    ev_ready = 1'b1;
    idle(5);
    chk("got_cnt35", 18'(got.size()), 18'd2);
    chk_got("sat_key", 0, {2'd1, 16'h0033});
    chk_got("sat_mouse", 1, {2'd0, 16'h7FFD});

    // Fill the FIFO past capacity behind a held mouse event.
    ev_ready = 1'b0; got.delete();
    strobe(2'd0, 8'h00);
    tick();
    for (int i = 0; i < DEPTH + 1; i++) strobe(2'd2, 8'(8'hA0 + i));
    chk("level_full", 18'(kbd_level), 18'd8);
    chk("ovf_set", 18'(kbd_overflow), 18'd1);
    ev_ready = 1'b1;
    idle(14);
    chk("got_cnt36", 18'(got.size()), 18'd9);
    chk_got("ovf_mouse", 0, {2'd0, 16'h0000});
    for (int i = 0; i < DEPTH; i++) chk_got("ovf_key", i + 1, {2'd1, 8'h00, 8'(8'hA0 + i)});

    // Arbitration with key and mouse pending together.
`ifdef KMS_RR_EN
    exp37[0] = {2'd1, 16'h0021}; exp37[1] = {2'd0, 16'h0100}; exp37[2] = {2'd1, 16'h0022};
`else
    exp37[0] = {2'd1, 16'h0021}; exp37[1] = {2'd1, 16'h0022}; exp37[2] = {2'd0, 16'h0100};
`endif
    ev_ready = 1'b0; got.delete();
    strobe(2'd2, 8'h21);
    tick();
    strobe(2'd2, 8'h22);
    strobe(2'd0, 8'h01);
    tick();
    ev_ready = 1'b1;
    idle(6);
    chk("got_cnt37", 18'(got.size()), 18'd3);
    for (int i = 0; i < 3; i++) chk_got("arb", i, exp37[i]);

    // Mouse delta arriving in the mouse grant cycle.
    got.delete();
    strobe(2'd0, 8'h07);
    strobe(2'd0, 8'h05);
    idle(5);
    chk("got_cnt38", 18'(got.size()), 18'd2);
    chk_got("grant_old", 0, {2'd0, 16'h0700});
    chk_got("grant_new", 1, {2'd0, 16'h0500});

    // Random traffic with random backpressure and button changes.
    for (int c = 0; c < 1500; c++) begin
      kms_strobe = ($urandom_range(0, 2) == 0);
      kms_type = 2'($urandom_range(0, 3));
      kms_data = 8'($urandom);
      ev_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) mouse_buttons = 3'($urandom);
      tick();
    end
    kms_strobe = 1'b0; ev_ready = 1'b1;
    idle(30);

    // Reset during HOLD drops ev_valid without waiting for a clock edge.
    ev_ready = 1'b0;
    strobe(2'd2, 8'h5A);
    idle(2);
    chk("hold_before_rst", 18'(ev_valid), 18'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_drop", 18'(ev_valid), 18'd0);
    model_reset();
    mouse_buttons = 3'b000;
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    check_all();
    ev_ready = 1'b1;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kms_event_sched.md
KMS_EVENT_SCHED -- requirements
Module: kms_event_sched

Interface
REQ-001 SHALL have parameter KBD_DEPTH, default 8, key FIFO depth; power of two, 4..16.
REQ-002 SHALL have port clk_sys  in  1  system clock; all logic is single-clock on its rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port kms_strobe  in  1  one-cycle event-valid pulse from the SPI user-IO block.
REQ-005 SHALL have port kms_type  in  2  event type: 0 mouse X, 1 mouse Y, 2 keycode, 3 OSD keycode.
REQ-006 SHALL have port kms_data  in  8  event payload; mouse types are two's-complement deltas.
REQ-007 SHALL have port mouse_buttons  in  3  live mouse button levels.
REQ-008 SHALL have port ev_valid  out  1  output event valid.
REQ-009 SHALL have port ev_kind  out  2  output event kind: 0 mouse, 1 key, 2 OSD key.
REQ-010 SHALL have port ev_data  out  16  mouse {dx,dy}; key {8'h00,code}.
REQ-011 SHALL have port ev_btn  out  3  button state reported with a mouse event; 0 for key events.
REQ-012 SHALL have port ev_ready  in  1  consumer accept; transfer occurs on a cycle with ev_valid and ev_ready both high.
REQ-013 SHALL have port kbd_overflow  out  1  sticky flag, set when a key is dropped.
REQ-014 SHALL have port kbd_level  out  5  current key FIFO occupancy.

Function
REQ-015 Types 0 and 1 SHALL add kms_data (signed) into acc_x or acc_y respectively, saturating to -128..127, one cycle after the strobe.
REQ-016 Types 2 and 3 SHALL push {type==3, data} into the key FIFO one cycle after the strobe.
REQ-017 A push to a full FIFO SHALL be dropped and SHALL set kbd_overflow; a simultaneous pop frees a slot, so the push is accepted.
REQ-018 mouse_pending SHALL set on any accepted mouse strobe, or when mouse_buttons differs from the last-reported buttons.
REQ-019 Output state machine IDLE SHALL behave as follows: ev_valid=0; if any candidate exists, load the output register and go to HOLD.
REQ-020 Output state machine HOLD SHALL behave as follows: ev_valid=1; ev_kind, ev_data and ev_btn are held stable until transfer.
REQ-021 On transfer, the block SHALL load the next candidate in the same cycle and stay in HOLD (back-to-back); with no candidate it SHALL go to IDLE.
REQ-022 A key grant SHALL pop the FIFO head, with ev_kind 1 or 2 taken from the stored OSD bit.
REQ-023 A mouse grant SHALL snapshot {acc_x,acc_y} and mouse_buttons into the output, clear both accumulators and mouse_pending, and update the last-reported buttons.
REQ-024 A mouse strobe in the grant cycle SHALL apply to the cleared accumulator (result is sat(0+data)) and SHALL re-set mouse_pending, so no delta is lost.
REQ-025 Latency: a strobe in cycle N with the output idle SHALL give ev_valid high in cycle N+2.
REQ-026 Key codes SHALL be delivered in arrival order, with no duplication and no loss except overflow drops.
REQ-027 kbd_level SHALL equal the number of pushes accepted minus pops; FIFO pointers wrap modulo KBD_DEPTH.

Reset
REQ-028 While reset_n is low, the block SHALL set ev_valid=0, ev_kind=0, ev_data=0, ev_btn=0, kbd_overflow=0, kbd_level=0, acc_x=acc_y=0, mouse_pending=0, last-reported buttons=0, state IDLE, and last-grant=mouse.
REQ-029 Reset asserted mid-HOLD SHALL abandon the held event; ev_valid SHALL drop asynchronously.
REQ-030 kbd_overflow SHALL clear only on reset.

Configuration
REQ-031 Macro KMS_RR_EN SHALL select the arbitration policy.
REQ-032 With KMS_RR_EN defined: when both key and mouse are candidates, the kind not granted last SHALL win.
REQ-033 Without KMS_RR_EN: key SHALL have fixed priority over mouse; the last-grant register is absent.

Verification
REQ-034 Keys 0x45, 0x46 (type 2), then 0x10 (type 3), with ev_ready=1: the bench SHALL see ev_kind 1,1,2 and ev_data 0x0045, 0x0046, 0x0010; first ev_valid at strobe+2.
REQ-035 Mouse X +100 twice, then Y -3, with ev_ready=0, then ready=1: the bench SHALL see one event with ev_data {0x7F,0xFD} (saturated).
REQ-036 Hold ev_ready=0 and push KBD_DEPTH+1 keys: kbd_level SHALL reach 8, kbd_overflow SHALL be 1, and only the first 8 codes SHALL be delivered.
REQ-037 Key and mouse both pending, ev_ready=1: with KMS_RR_EN the kinds SHALL alternate; without it, all keys SHALL drain before the mouse event.
REQ-038 Mouse X +5 arriving in the mouse grant cycle: the first event SHALL carry the old delta, and a second event SHALL follow with dx=0x05.
REQ-039 Assert reset_n low during HOLD: ev_valid SHALL go 0 immediately, and all outputs SHALL be at reset values after release.
